// File: rtl/slot_select_pkg.sv
// Shared types and defaults for the slot-select input conditioner.
// Optional feature macro used by the top level: SLT_BTN_REPEAT_EN (button auto-repeat).
package slot_select_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLT_W     = $clog2(NUM_SLOTS);

    localparam int DEF_DEB_CYCLES    = 1_000_000;
    localparam int DEF_DEB_W         = 20;
    localparam int DEF_FLUSH_CYCLES  = 8;
    localparam int DEF_REPEAT_CYCLES = 50_000_000;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Step the slot code by one, wrapping naturally at the code width.
    function automatic logic [SLT_W-1:0] slot_step(input logic [SLT_W-1:0] code, input logic up);
        return up ? code + SLT_W'(1) : code - SLT_W'(1);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchroniser followed by a consecutive-disagreement debounce counter.
module debounce_cell #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int DEB_W      = 20
) (
    input  logic iclk,
    input  logic irst,
    input  logic raw,
    output logic stable
);

    logic             sync1, sync2;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // One agreeing cycle restarts the count; the output flips only after a full run.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/slot_select_ctrl.sv
// Slot-select conditioner: debounced inputs, slot code, change pulse and flush-busy window.
// Define SLT_BTN_REPEAT_EN to enable auto-repeat while a button is held.
module slot_select_ctrl
    import slot_select_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int DEB_W         = DEF_DEB_W,
    parameter int FLUSH_CYCLES  = DEF_FLUSH_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             ibtn_next,
    input  logic             ibtn_prev,
    input  logic [SLT_W-1:0] islt_sw,
    input  logic             imode,
    output logic [SLT_W-1:0] oslt,
    output logic             oslt_chg,
    output logic             obusy
);

    localparam int NUM_IN = 5;
    localparam int FL_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    // Bit order: 0 next, 1 prev, 2 sw[0], 3 sw[1], 4 mode
    logic [NUM_IN-1:0] raw, deb, deb_q;
    assign raw = {imode, islt_sw[1], islt_sw[0], ibtn_prev, ibtn_next};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
        debounce_cell #(
            .DEB_CYCLES(DEB_CYCLES),
            .DEB_W     (DEB_W)
        ) u_deb (
            .iclk  (iclk),
            .irst  (irst),
            .raw   (raw[i]),
            .stable(deb[i])
        );
    end

    logic press_next, press_prev;
    logic ev_next, ev_prev;
    assign press_next = deb[0] & ~deb_q[0];
    assign press_prev = deb[1] & ~deb_q[1];

    // Event stage: registered press pulses; deb_q also serves as the registered switch/mode view.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            deb_q   <= '0;
            ev_next <= 1'b0;
            ev_prev <= 1'b0;
        end else begin
            deb_q   <= deb;
            ev_next <= press_next;
            ev_prev <= press_prev;
        end
    end

    logic step_next, step_prev;

`ifdef SLT_BTN_REPEAT_EN
    localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    logic [RP_W-1:0] rep_cnt;
    logic            rep_next, rep_prev;

    // Timer restarts on every press and free-runs while either button stays held.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            rep_cnt  <= '0;
            rep_next <= 1'b0;
            rep_prev <= 1'b0;
        end else begin
            rep_next <= 1'b0;
            rep_prev <= 1'b0;
            if (press_next || press_prev || !(deb_q[0] || deb_q[1])) begin
                rep_cnt <= '0;
            end else if (rep_cnt == RP_W'(REPEAT_CYCLES - 1)) begin
                rep_cnt  <= '0;
                rep_next <= deb_q[0];
                rep_prev <= deb_q[1];
            end else begin
                rep_cnt <= rep_cnt + RP_W'(1);
            end
        end
    end

    assign step_next = ev_next | rep_next;
    assign step_prev = ev_prev | rep_prev;
`else
    assign step_next = ev_next;
    assign step_prev = ev_prev;
`endif

    state_e           state;
    logic [FL_W-1:0]  flush_cnt;
    logic             fire;
    logic [SLT_W-1:0] nxt_slt;
    logic [SLT_W-1:0] sw_q;
    logic             mode_q;

    assign sw_q   = deb_q[3:2];
    assign mode_q = deb_q[4];

    // Only IDLE accepts changes: presses during a flush are lost, switch levels are re-examined.
    always_comb begin
        fire    = 1'b0;
        nxt_slt = oslt;
        if (state == IDLE) begin
            if (mode_q) begin
                if (step_next ^ step_prev) begin
                    fire    = 1'b1;
                    nxt_slt = slot_step(oslt, step_next);
                end
            end else if (sw_q != oslt) begin
                fire    = 1'b1;
                nxt_slt = sw_q;
            end
        end
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state     <= IDLE;
            oslt      <= '0;
            oslt_chg  <= 1'b0;
            obusy     <= 1'b0;
            flush_cnt <= '0;
        end else begin
            oslt_chg <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        oslt      <= nxt_slt;
                        oslt_chg  <= 1'b1;
                        obusy     <= 1'b1;
                        flush_cnt <= FL_W'(FLUSH_CYCLES - 1);
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= IDLE;
                        obusy <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_select_ctrl.sv
// Directed bench for slot_select_ctrl with a scoreboard of expected slot changes.
module tb_slot_select_ctrl;

    localparam int DEB   = 4;
    localparam int FLUSH = 8;
    localparam int REP   = 20;
    localparam int LAT   = DEB + 3;

    logic       iclk = 1'b0;
    logic       irst;
    logic       ibtn_next, ibtn_prev, imode;
    logic [1:0] islt_sw;
    logic [1:0] oslt;
    logic       oslt_chg, obusy;

    slot_select_ctrl #(
        .DEB_CYCLES   (DEB),
        .DEB_W        (3),
        .FLUSH_CYCLES (FLUSH),
        .REPEAT_CYCLES(REP)
    ) dut (
        .iclk     (iclk),
        .irst     (irst),
        .ibtn_next(ibtn_next),
        .ibtn_prev(ibtn_prev),
        .islt_sw  (islt_sw),
        .imode    (imode),
        .oslt     (oslt),
        .oslt_chg (oslt_chg),
        .obusy    (obusy)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc++;

    typedef struct {
        logic [1:0] val;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_chg(input logic [1:0] v, input int c);
        sb.push_back('{val: v, cyc: c});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge iclk);
    endtask

    // Monitor: every pulse must match the scoreboard head; every busy window must be FLUSH long.
    int busy_run = 0;
    always @(negedge iclk) begin
        if (!irst) begin
            busy_run = 0;
        end else begin
            if (oslt_chg) begin
                check("chg_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("chg_val", 32'(oslt), 32'(e.val));
                    check("chg_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (obusy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_len", 32'(busy_run), 32'(FLUSH));
                busy_run = 0;
            end
        end
    end

    int n0;

    initial begin
        irst      = 1'b0;
        ibtn_next = 1'b0;
        ibtn_prev = 1'b0;
        imode     = 1'b0;
        islt_sw   = 2'b00;
        wait_cyc(3);
        check("rst_oslt", 32'(oslt), 32'd0);
        check("rst_chg", 32'(oslt_chg), 32'd0);
        check("rst_busy", 32'(obusy), 32'd0);
        irst = 1'b1;

        // Button mode, four next presses
        imode = 1'b1;
        wait_cyc(12);
        for (int i = 0; i < 4; i++) begin
            n0 = cyc;
            expect_chg(2'((i + 1) % 4), n0 + 1 + LAT);
            ibtn_next = 1'b1;
            wait_cyc(10);
            ibtn_next = 1'b0;
            wait_cyc(20);
        end
        check("t1_oslt", 32'(oslt), 32'd0);

        // prev wraps 0 -> 3, then a simultaneous press cancels
        n0 = cyc;
        expect_chg(2'd3, n0 + 1 + LAT);
        ibtn_prev = 1'b1;
        wait_cyc(10);
        ibtn_prev = 1'b0;
        wait_cyc(20);
        ibtn_next = 1'b1;
        ibtn_prev = 1'b1;
        wait_cyc(10);
        ibtn_next = 1'b0;
        ibtn_prev = 1'b0;
        wait_cyc(20);
        check("t2_cancel_oslt", 32'(oslt), 32'd3);
        check("t2_cancel_busy", 32'(obusy), 32'd0);

        // Bouncing next never settles
        for (int i = 0; i < 10; i++) begin
            ibtn_next = ~ibtn_next;
            wait_cyc(2);
        end
        ibtn_next = 1'b0;
        wait_cyc(20);
        check("t3_bounce_oslt", 32'(oslt), 32'd3);

        // Switch mode: entering loads sw (00), then 00->10, then 01 during the flush
        n0 = cyc;
        expect_chg(2'd0, n0 + 1 + LAT);
        imode = 1'b0;
        wait_cyc(30);
        n0 = cyc;
        expect_chg(2'd2, n0 + 1 + LAT);
        islt_sw = 2'b10;
        wait_cyc(4);
        expect_chg(2'd1, n0 + 1 + LAT + FLUSH + 1);
        islt_sw = 2'b01;
        wait_cyc(30);
        check("t4_oslt", 32'(oslt), 32'd1);

        // Back to button mode; switches no longer matter
        imode = 1'b1;
        wait_cyc(20);
        islt_sw = 2'b00;
        wait_cyc(10);
        check("t5_mode_keep", 32'(oslt), 32'd1);

        // A prev press landing in the flush is dropped
        n0 = cyc;
        expect_chg(2'd2, n0 + 1 + LAT);
        ibtn_next = 1'b1;
        wait_cyc(3);
        ibtn_prev = 1'b1;
        wait_cyc(7);
        ibtn_next = 1'b0;
        ibtn_prev = 1'b0;
        wait_cyc(25);
        check("t5_drop_oslt", 32'(oslt), 32'd2);

        // Reset in the middle of a flush
        n0 = cyc;
        expect_chg(2'd3, n0 + 1 + LAT);
        ibtn_next = 1'b1;
        wait_cyc(10);
        ibtn_next = 1'b0;
        wait_cyc(3);
        check("t5_pre_rst_busy", 32'(obusy), 32'd1);
        #2 irst = 1'b0;
        #1;
        check("t5_rst_oslt", 32'(oslt), 32'd0);
        check("t5_rst_busy", 32'(obusy), 32'd0);
        check("t5_rst_chg", 32'(oslt_chg), 32'd0);
        wait_cyc(3);
        irst = 1'b1;
        wait_cyc(30);
        check("t5_post_oslt", 32'(oslt), 32'd0);
        check("t5_post_busy", 32'(obusy), 32'd0);

        // Long hold of next
        n0 = cyc;
        expect_chg(2'd1, n0 + 1 + LAT);
`ifdef SLT_BTN_REPEAT_EN
        expect_chg(2'd2, n0 + 1 + LAT + REP);
        expect_chg(2'd3, n0 + 1 + LAT + 2 * REP);
        expect_chg(2'd0, n0 + 1 + LAT + 3 * REP);
`endif
        ibtn_next = 1'b1;
        wait_cyc(78);
        ibtn_next = 1'b0;
        wait_cyc(40);
`ifdef SLT_BTN_REPEAT_EN
        check("t6_hold_oslt", 32'(oslt), 32'd0);
`else
        check("t6_hold_oslt", 32'(oslt), 32'd1);
`endif
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
